reg_scoreboard: RTL and testbench

- Issue-stage hazard controller that sits between the instruction decoder and the execute pipeline.
- Tracks outstanding register writes per architectural register and holds the decoder back while a required source (rs/rt) has a pending write.
- Releases registers on writeback and clears all state on pipeline flush.
- Counts total in-flight writers to bound pipeline occupancy.

---
 rtl/arch_pkg.sv | 10 +
 rtl/sb_counter.sv | 35 +++
 rtl/reg_scoreboard.sv | 116 +++++++++++
 tb/tb_reg_scoreboard.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arch_pkg.sv
// Shared architectural constants and types for the issue-stage scoreboard.
package arch_pkg;

    localparam int NUM_REGS     = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int MAX_INFLIGHT = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-writer counter: saturating +1/-1, clear has priority.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic dec_ok;

    assign nonzero   = (cnt != '0);
    assign underflow = dec & ~nonzero;
    assign dec_ok    = dec & nonzero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec_ok && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end else if (!inc && dec_ok) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage RAW/occupancy hazard controller with per-register writer counts.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear hazards.
module reg_scoreboard
    import arch_pkg::*;
#(
    parameter int NUM_REGS     = arch_pkg::NUM_REGS,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = arch_pkg::MAX_INFLIGHT,
    localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    input  logic [4:0]          rs,
    input  logic                require_rs,
    input  logic [4:0]          rt,
    input  logic                require_rt,
    input  logic [4:0]          wd,
    input  logic                reg_write,
    input  logic                ex_ready,
    input  logic                wb_valid,
    input  logic [4:0]          wb_addr,
    input  logic                flush,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [IW-1:0]       inflight_cnt,
    output logic                sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] nonzero;
    logic [NUM_REGS-1:0] underflow;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] busy;
    logic [IW-1:0]       inflight_eff;
    logic                inc_any;
    logic                dec_any;
    logic                err_set;
    logic                raw_hazard;
    logic                full_hazard;
    logic                wd_full;

    assign cnt[0]       = '0;
    assign nonzero[0]   = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_hit
        assign wb_hit[r] = wb_valid & (wb_addr == reg_addr_t'(r));
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (issue & reg_write & (wd == reg_addr_t'(r))),
            .dec       (wb_hit[r]),
            .clr       (flush),
            .cnt       (cnt[r]),
            .nonzero   (nonzero[r]),
            .underflow (underflow[r])
        );
    end

    assign pending_mask = nonzero;
    assign inc_any      = issue & reg_write & (wd != '0);
    assign dec_any      = wb_valid & (wb_addr != '0) & nonzero[wb_addr] &
                          (inflight_cnt != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
    // A writeback retiring the last writer frees the register this cycle.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
        assign busy[r] = nonzero[r] & ~(wb_hit[r] & (cnt[r] == CNT_W'(1)));
    end
    assign inflight_eff = inflight_cnt - IW'(dec_any);
    assign wd_full      = (cnt[wd] == CNT_MAX) & ~wb_hit[wd];
`else
    assign busy         = nonzero;
    assign inflight_eff = inflight_cnt;
    assign wd_full      = (cnt[wd] == CNT_MAX);
`endif

    always_comb begin
        raw_hazard  = (require_rs & (rs != '0) & busy[rs]) |
                      (require_rt & (rt != '0) & busy[rt]);
        full_hazard = reg_write & (wd != '0) &
                      ((inflight_eff == IW'(MAX_INFLIGHT)) | wd_full);
        stall = ~rst_n |
                (dec_valid & (raw_hazard | full_hazard | ~ex_ready | flush));
        issue = dec_valid & ~stall;
    end

    assign err_set = ~flush & wb_valid & (wb_addr != '0) &
                     ((|underflow) | (inflight_cnt == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_cnt <= '0;
            sb_err       <= 1'b0;
        end else begin
            if (err_set) begin
                sb_err <= 1'b1;
            end
            if (flush) begin
                inflight_cnt <= '0;
            end else if (inc_any && !dec_any) begin
                inflight_cnt <= inflight_cnt + 1'b1;
            end else if (!inc_any && dec_any) begin
                inflight_cnt <= inflight_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed test for reg_scoreboard; expectations adapt to SCOREBOARD_WB_BYPASS_EN.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [4:0]  rs;
    logic        require_rs;
    logic [4:0]  rt;
    logic        require_rt;
    logic [4:0]  wd;
    logic        reg_write;
    logic        ex_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        stall;
    logic        issue;
    logic [31:0] pending_mask;
    logic [2:0]  inflight_cnt;
    logic        sb_err;

    int total = 0;
    int bad   = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .rs           (rs),
        .require_rs   (require_rs),
        .rt           (rt),
        .require_rt   (require_rt),
        .wd           (wd),
        .reg_write    (reg_write),
        .ex_ready     (ex_ready),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .flush        (flush),
        .stall        (stall),
        .issue        (issue),
        .pending_mask (pending_mask),
        .inflight_cnt (inflight_cnt),
        .sb_err       (sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        dec_valid  = 0; rs = 0; require_rs = 0; rt = 0; require_rt = 0;
        wd = 0; reg_write = 0; wb_valid = 0; wb_addr = 0; flush = 0;
        ex_ready = 1;
    endtask

    task automatic wr(input logic [4:0] d);
        quiet();
        dec_valid = 1; reg_write = 1; wd = d;
    endtask

    task automatic wb(input logic [4:0] a);
        quiet();
        wb_valid = 1; wb_addr = a;
    endtask

    initial begin
        quiet();
        rst_n = 0;
        step(); step();
        #1 chk("rst_stall", stall, 1);
        chk("rst_issue", issue, 0);
        rst_n = 1;
        step();
        #1 chk("idle_stall", stall, 0);
        chk("idle_mask", pending_mask, 0);
        chk("idle_infl", inflight_cnt, 0);
        chk("idle_err", sb_err, 0);

        // RAW stall on r5
        wr(5);
        #1 chk("raw_wr_issue", issue, 1);
        step();
        quiet();
        dec_valid = 1; rs = 5; require_rs = 1;
        #1 chk("raw_stall0", stall, 1);
        chk("raw_mask5", pending_mask[5], 1);
        chk("raw_infl", inflight_cnt, 1);
        step();
        #1 chk("raw_stall1", stall, 1);
        wb_valid = 1; wb_addr = 5;
        #1 chk("raw_wb_issue", issue, BYP);
        step();
        wb_valid = 0;
        #1 chk("raw_after_issue", issue, 1);
        chk("raw_mask5_clr", pending_mask[5], 0);
        chk("raw_infl0", inflight_cnt, 0);

        // register 0 and unused sources
        wr(0);
        #1 chk("r0_wr_issue", issue, 1);
        step();
        quiet();
        dec_valid = 1; rs = 0; require_rs = 1;
        #1 chk("r0_rd_stall", stall, 0);
        chk("r0_infl", inflight_cnt, 0);
        chk("r0_mask", pending_mask, 0);
        wr(5);
        step();
        quiet();
        dec_valid = 1; rt = 5; require_rt = 0;
        #1 chk("rt_unused_stall", stall, 0);
        require_rt = 1;
        #1 chk("rt_used_stall", stall, 1);
        wb(5);
        step();
        quiet();
        wb_valid = 1; wb_addr = 0;
        step();
        quiet();
        #1 chk("wb0_err", sb_err, 0);
        chk("wb0_infl", inflight_cnt, 0);

        // occupancy limit
        for (int i = 1; i <= 4; i++) begin
            wr(5'(i));
            #1 chk("occ_issue", issue, 1);
            step();
        end
        #1 chk("occ_full", inflight_cnt, 4);
        chk("occ_mask", pending_mask, 32'h1e);
        wr(6);
        #1 chk("occ_5th_stall", stall, 1);
        wb_valid = 1; wb_addr = 1;
        #1 chk("occ_wb_cyc", issue, BYP);
        step();
        wb_valid = 0;
        #1 chk("occ_5th", issue, !BYP);
        step();
        quiet();
        #1 chk("occ_cnt", inflight_cnt, 4);
        chk("occ_mask2", pending_mask, 32'h5c);
        for (int i = 0; i < 4; i++) begin
            wb(5'(i == 3 ? 6 : i + 2));
            step();
        end
        quiet();
        #1 chk("occ_drain", inflight_cnt, 0);

        // simultaneous issue and writeback on r7
        wr(7);
        step();
        wr(7);
        wb_valid = 1; wb_addr = 7;
        #1 chk("sim_issue", issue, 1);
        step();
        quiet();
        #1 chk("sim_infl", inflight_cnt, 1);
        chk("sim_mask7", pending_mask[7], 1);
        wb(7);
        step();
        quiet();
        #1 chk("sim_clr", pending_mask, 0);

        // flush, then error on stale writeback
        for (int i = 8; i <= 10; i++) begin
            wr(5'(i));
            step();
        end
        #1 chk("fl_infl3", inflight_cnt, 3);
        wr(11);
        flush = 1; wb_valid = 1; wb_addr = 8;
        #1 chk("fl_stall", stall, 1);
        chk("fl_issue", issue, 0);
        step();
        quiet();
        #1 chk("fl_infl0", inflight_cnt, 0);
        chk("fl_mask0", pending_mask, 0);
        chk("fl_err0", sb_err, 0);
        wb(9);
        step();
        quiet();
        #1 chk("err_set", sb_err, 1);
        chk("err_infl", inflight_cnt, 0);
        step(); step();
        #1 chk("err_hold", sb_err, 1);
        rst_n = 0;
        step();
        rst_n = 1;
        #1 chk("err_rst", sb_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
